// File: rtl/dt_dispatch_pkg.sv
// Shared types and header layout for the data line dispatcher.
// Line geometry normally comes from the project defines file; fallbacks keep this file standalone.
`ifndef DATA_LINE_WIDTH
`define DATA_LINE_WIDTH 64
`endif
`ifndef NUM_PUS_PER_CLUSTER_BITS
`define NUM_PUS_PER_CLUSTER_BITS 4
`endif

package dt_dispatch_pkg;

    localparam int unsigned DATA_LINE_WIDTH          = `DATA_LINE_WIDTH;
    localparam int unsigned NUM_PUS_PER_CLUSTER_BITS = `NUM_PUS_PER_CLUSTER_BITS;

    localparam int unsigned HDR_OP_LSB      = 0;
    localparam int unsigned HDR_OP_W        = 2;
    localparam int unsigned HDR_CLUSTER_LSB = 8;
    localparam int unsigned HDR_CLUSTER_W   = 8;
    localparam int unsigned HDR_PU_LSB      = 16;
    localparam int unsigned HDR_PU_W        = 8;
    localparam int unsigned HDR_CNT_LSB     = 32;
    localparam int unsigned HDR_CNT_W       = 32;

    typedef enum logic [1:0] {
        OpProg0 = 2'd0,
        OpProg1 = 2'd1,
        OpProg2 = 2'd2,
        OpData  = 2'd3
    } opcode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StProg = 2'd1,
        StData = 2'd2
    } state_e;

endpackage

// File: rtl/dispatch_out_slot.sv
// Single per-cluster output register: load when free, drain on ready, otherwise hold.
module dispatch_out_slot
    import dt_dispatch_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                load,
    input  logic [DATA_LINE_WIDTH-1:0]          line_in,
    input  logic                                last_in,
    input  logic                                ctrl_in,
    input  logic [1:0]                          prog_in,
    input  logic [NUM_PUS_PER_CLUSTER_BITS-1:0] pu_in,
    input  logic                                out_ready,
    output logic                                free,
    output logic                                out_valid,
    output logic [DATA_LINE_WIDTH-1:0]          out_line,
    output logic                                out_last,
    output logic                                out_ctrl,
    output logic [1:0]                          out_prog,
    output logic [NUM_PUS_PER_CLUSTER_BITS-1:0] out_pu
);

    logic                                valid_q;
    logic [DATA_LINE_WIDTH-1:0]          line_q;
    logic                                last_q;
    logic                                ctrl_q;
    logic [1:0]                          prog_q;
    logic [NUM_PUS_PER_CLUSTER_BITS-1:0] pu_q;

    // Payload registers only change on load, so they stay stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            line_q  <= '0;
            last_q  <= 1'b0;
            ctrl_q  <= 1'b0;
            prog_q  <= '0;
            pu_q    <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            line_q  <= line_in;
            last_q  <= last_in;
            ctrl_q  <= ctrl_in;
            prog_q  <= prog_in;
            pu_q    <= pu_in;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign free      = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_line  = line_q;
    assign out_last  = last_q;
    assign out_ctrl  = ctrl_q;
    assign out_prog  = prog_q;
    assign out_pu    = pu_q;

endmodule

// File: rtl/data_line_dispatcher.sv
// Decodes job headers and routes payload lines to one cluster (program) or all clusters (data).
module data_line_dispatcher
    import dt_dispatch_pkg::*;
#(
    parameter int unsigned NUM_CLUSTERS = 4,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic [DATA_LINE_WIDTH-1:0]                       in_line,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    output logic [NUM_CLUSTERS*DATA_LINE_WIDTH-1:0]          out_line,
    output logic [NUM_CLUSTERS-1:0]                          out_valid,
    output logic [NUM_CLUSTERS-1:0]                          out_last,
    output logic [NUM_CLUSTERS-1:0]                          out_ctrl,
    output logic [NUM_CLUSTERS*2-1:0]                        out_prog,
    output logic [NUM_CLUSTERS*NUM_PUS_PER_CLUSTER_BITS-1:0] out_pu,
    input  logic [NUM_CLUSTERS-1:0]                          out_ready,
    output logic                                             err_bad_cluster,
    output logic [CNT_WIDTH-1:0]                             lines_dispatched
);

    localparam int unsigned PuW = NUM_PUS_PER_CLUSTER_BITS;

    state_e                     state_q, state_d;
    logic [CNT_WIDTH-1:0]       remain_q, remain_d;
    opcode_e                    op_q;
    logic [HDR_CLUSTER_W-1:0]   cluster_q;
    logic [PuW-1:0]             pu_q;
    logic                       err_q;
    logic [CNT_WIDTH-1:0]       cnt_q;
    logic                       en_q;

    opcode_e                    hdr_op;
    logic [CNT_WIDTH-1:0]       hdr_cnt;
    logic [NUM_CLUSTERS-1:0]    target_sel;
    logic                       target_ok;
    logic                       target_free;
    logic [NUM_CLUSTERS-1:0]    slot_free;
    logic [NUM_CLUSTERS-1:0]    load;
    logic                       accept;
    logic                       slot_last;
    logic                       slot_ctrl;
    logic [1:0]                 slot_prog;
    logic [PuW-1:0]             slot_pu;

    assign hdr_op  = opcode_e'(in_line[HDR_OP_LSB +: HDR_OP_W]);
    assign hdr_cnt = in_line[HDR_CNT_LSB +: CNT_WIDTH];

    // An out-of-range cluster id matches no slot, which is how bad targets are detected.
    always_comb begin
        target_sel = '0;
        for (int c = 0; c < NUM_CLUSTERS; c++) begin
            target_sel[c] = (cluster_q == HDR_CLUSTER_W'(c));
        end
    end

    assign target_ok   = |target_sel;
    assign target_free = |(target_sel & slot_free);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    remain_d = hdr_cnt;
                    if (hdr_cnt != '0) begin
                        state_d = (hdr_op == OpData) ? StData : StProg;
                    end
                end
            end
            StProg, StData: begin
                if (accept) begin
                    remain_d = remain_q - 1'b1;
                    if (remain_q == CNT_WIDTH'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        load     = '0;
        case (state_q)
            StIdle:  in_ready = en_q;
            StProg:  in_ready = en_q && (!target_ok || target_free);
            StData:  in_ready = en_q && (&slot_free);
            default: in_ready = 1'b0;
        endcase
        accept = in_valid && in_ready;
        if (accept && state_q == StProg) begin
            load = target_sel;
        end else if (accept && state_q == StData) begin
            load = '1;
        end
    end

    assign slot_last = (remain_q == CNT_WIDTH'(1));
    assign slot_ctrl = (state_q == StProg);
    assign slot_prog = (state_q == StData) ? OpData : op_q;
    assign slot_pu   = (state_q == StData) ? '0 : pu_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= OpProg0;
            cluster_q <= '0;
            pu_q      <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            en_q      <= 1'b0;
        end else begin
            en_q <= 1'b1;
            if (accept && state_q == StIdle) begin
                op_q      <= hdr_op;
                cluster_q <= in_line[HDR_CLUSTER_LSB +: HDR_CLUSTER_W];
                pu_q      <= in_line[HDR_PU_LSB +: PuW];
            end
            if (accept && state_q == StProg && !target_ok) begin
                err_q <= 1'b1;
            end
            if (|load) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign err_bad_cluster  = err_q;
    assign lines_dispatched = cnt_q;

    for (genvar c = 0; c < NUM_CLUSTERS; c++) begin : g_slot
        dispatch_out_slot u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[c]),
            .line_in   (in_line),
            .last_in   (slot_last),
            .ctrl_in   (slot_ctrl),
            .prog_in   (slot_prog),
            .pu_in     (slot_pu),
            .out_ready (out_ready[c]),
            .free      (slot_free[c]),
            .out_valid (out_valid[c]),
            .out_line  (out_line[c*DATA_LINE_WIDTH +: DATA_LINE_WIDTH]),
            .out_last  (out_last[c]),
            .out_ctrl  (out_ctrl[c]),
            .out_prog  (out_prog[c*2 +: 2]),
            .out_pu    (out_pu[c*PuW +: PuW])
        );
    end

endmodule
